// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
// Contents: DATA_W (register/datapath width), ADDR_W (register address width),
//           ZERO_REG (index of the hard-wired zero register).
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/reg_file_rdport.sv
// Combinational read port of the register file.
// The port selects one entry and forces the zero register to read as 0.
// With REGFILE_BYPASS_EN defined, a pending write to the same address is
// forwarded to the output in the same cycle.
// Ports:
//   rd_addr  in   ADDR_W              read address
//   regs     in   2**ADDR_W x DATA_W  flattened storage (entry 0 tied to 0)
//   wr_en    in   1                   write enable (REGFILE_BYPASS_EN only)
//   wr_addr  in   ADDR_W              write address (REGFILE_BYPASS_EN only)
//   wr_data  in   DATA_W              write data (REGFILE_BYPASS_EN only)
//   reset    in   1                   sync reset; blocks forwarding (REGFILE_BYPASS_EN only)
//   rd_data  out  DATA_W              read data
module reg_file_rdport #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
`ifdef REGFILE_BYPASS_EN
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic                                reset,
`endif
  output logic [DATA_W-1:0]                   rd_data
);

  import cpu_pkg::*;

  logic rd_is_zero;
  assign rd_is_zero = (rd_addr == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;
  // Forward only writes that will actually land at the coming edge.
  assign fwd_hit = wr_en && !reset && (wr_addr != ADDR_W'(ZERO_REG)) && (rd_addr == wr_addr);
`endif

  always_comb begin
    rd_data = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (fwd_hit) begin
      rd_data = wr_data;
    end
`endif
    if (rd_is_zero) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, register 0 hard-wired to zero.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding on reads).
// Ports:
//   clk        in   1       clock, state updates on rising edge
//   reset      in   1       synchronous active-high clear of all registers
//   R_Addr_A   in   ADDR_W  read address, port A
//   R_Addr_B   in   ADDR_W  read address, port B
//   W_Addr     in   ADDR_W  write address
//   W_Data     in   DATA_W  write data
//   Write_Reg  in   1       write enable
//   R_Data_A   out  DATA_W  read data, port A
//   R_Data_B   out  DATA_W  read data, port B
module reg_file #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B
);

  import cpu_pkg::*;

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Entry 0 is never stored.
  logic [DATA_W-1:0] regs_q [1:Depth-1];
  logic [Depth-1:0][DATA_W-1:0] regs_flat;
  logic wr_fire;

  assign wr_fire = Write_Reg && (W_Addr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[W_Addr] <= W_Data;
    end
  end

  always_comb begin
    regs_flat[0] = '0;
    for (int i = 1; i < Depth; i++) begin
      regs_flat[i] = regs_q[i];
    end
  end

  reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .rd_addr (R_Addr_A),
    .regs    (regs_flat),
`ifdef REGFILE_BYPASS_EN
    .wr_en   (Write_Reg),
    .wr_addr (W_Addr),
    .wr_data (W_Data),
    .reset   (reset),
`endif
    .rd_data (R_Data_A)
  );

  reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .rd_addr (R_Addr_B),
    .regs    (regs_flat),
`ifdef REGFILE_BYPASS_EN
    .wr_en   (Write_Reg),
    .wr_addr (W_Addr),
    .wr_data (W_Data),
    .reset   (reset),
`endif
    .rd_data (R_Data_B)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file, default build or REGFILE_BYPASS_EN.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;

  int total = 0;
  int bad   = 0;

  reg_file dut (
    .clk       (clk),
    .reset     (reset),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .Write_Reg (Write_Reg),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    Write_Reg = 1'b0;
    W_Addr    = '0;
    W_Data    = '0;
    R_Addr_A  = '0;
    R_Addr_B  = '0;
    tick();
    reset = 1'b0;

    // Every entry reads 0 after reset.
    for (int i = 0; i < 32; i++) begin
      R_Addr_A = 5'(i);
      R_Addr_B = 5'(31 - i);
      #1;
      check_val($sformatf("rst_a%0d", i), R_Data_A, 32'h0);
      check_val($sformatf("rst_b%0d", 31 - i), R_Data_B, 32'h0);
    end

    // Write r1.
    Write_Reg = 1'b1; W_Addr = 5'd1; W_Data = 32'h1111_1111;
    tick();
    Write_Reg = 1'b0;
    R_Addr_A = 5'd1; R_Addr_B = 5'd0;
    #1;
    check_val("wr_r1_a", R_Data_A, 32'h1111_1111);
    check_val("wr_r1_b0", R_Data_B, 32'h0);

    // Write r3.
    Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'h2222_2222;
    tick();
    Write_Reg = 1'b0;
    R_Addr_B = 5'd3;
    #1;
    check_val("wr_r3_b", R_Data_B, 32'h2222_2222);
    check_val("keep_r1_a", R_Data_A, 32'h1111_1111);

    // Same-cycle address tracking and both ports on one register.
    R_Addr_A = 5'd3;
    #1;
    check_val("track_a3", R_Data_A, 32'h2222_2222);
    R_Addr_B = 5'd1;
    #1;
    check_val("track_b1", R_Data_B, 32'h1111_1111);
    R_Addr_A = 5'd2;
    #1;
    check_val("unwritten_r2", R_Data_A, 32'h0);

    // Disabled write.
    Write_Reg = 1'b0; W_Addr = 5'd7; W_Data = 32'h3333_3333;
    tick();
    R_Addr_B = 5'd7;
    #1;
    check_val("dis_r7", R_Data_B, 32'h0);

    // Top entry.
    Write_Reg = 1'b1; W_Addr = 5'd31; W_Data = 32'hDEAD_BEEF;
    tick();
    Write_Reg = 1'b0;
    R_Addr_A = 5'd31;
    #1;
    check_val("wr_r31", R_Data_A, 32'hDEAD_BEEF);

    // Reset beats a simultaneous write.
    reset = 1'b1; Write_Reg = 1'b1; W_Addr = 5'd15; W_Data = 32'h4444_4444;
    R_Addr_A = 5'd15; R_Addr_B = 5'd15;
    #1;
    check_val("rst_nofwd_15", R_Data_A, 32'h0);
    tick();
    reset = 1'b0; Write_Reg = 1'b0;
    check_val("rst_pri_r15", R_Data_B, 32'h0);
    R_Addr_A = 5'd1; R_Addr_B = 5'd3;
    #1;
    check_val("rst_r1", R_Data_A, 32'h0);
    check_val("rst_r3", R_Data_B, 32'h0);
    R_Addr_A = 5'd31;
    #1;
    check_val("rst_r31", R_Data_A, 32'h0);

    // Zero register ignores writes, also before the edge.
    Write_Reg = 1'b1; W_Addr = 5'd0; W_Data = 32'hFFFF_FFFF;
    R_Addr_A = 5'd0;
    #1;
    check_val("zero_pre", R_Data_A, 32'h0);
    tick();
    Write_Reg = 1'b0;
    check_val("zero_post", R_Data_A, 32'h0);

    // Write-through versus registered visibility.
    Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'hA5A5_A5A5;
    R_Addr_A = 5'd5; R_Addr_B = 5'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("byp_pre_a", R_Data_A, 32'hA5A5_A5A5);
`else
    check_val("byp_pre_a", R_Data_A, 32'h0);
`endif
    check_val("byp_other_b", R_Data_B, 32'h0);
    tick();
    Write_Reg = 1'b0;
    W_Data = 32'h0;
    R_Addr_B = 5'd5;
    #1;
    check_val("byp_post_a", R_Data_A, 32'hA5A5_A5A5);
    check_val("byp_post_b", R_Data_B, 32'hA5A5_A5A5);

    // Overwrite keeps old value on the port until the edge unless forwarded.
    Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'h0BAD_F00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("ovr_pre_b", R_Data_B, 32'h0BAD_F00D);
`else
    check_val("ovr_pre_b", R_Data_B, 32'hA5A5_A5A5);
`endif
    tick();
    Write_Reg = 1'b0;
    check_val("ovr_post_a", R_Data_A, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
